// File: rtl/gate_truth_table_sweep.sv
// Steps 32 {code,a,b,c} vectors into a three-input gate and captures its output per vector into o_table.
// Define GATE_SWEEP_COMPARE_EN to add i_expect/o_match, a check of the final table against an expected value.
module gate_truth_table_sweep #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_a,
  output logic        o_b,
  output logic        o_c,
  output logic [1:0]  o_code,
  input  logic        i_f,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_table
`ifdef GATE_SWEEP_COMPARE_EN
  ,
  input  logic [31:0] i_expect,
  output logic        o_match
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] WAIT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle time each vector goes straight to sampling.
  localparam state_t FIRST = (SETTLE == 0) ? SAMPLE : DRIVE;

  state_t      state, state_nx;
  logic [4:0]  vec, vec_nx;
  logic [3:0]  wait_cnt, wait_nx;
  logic [31:0] tab_nx;
  logic        start_ok;
  logic        busy_nx;
  logic        done_nx;
  logic [4:0]  drive_nx;
`ifdef GATE_SWEEP_COMPARE_EN
  logic        match_nx;
`endif

  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    wait_nx  = wait_cnt;
    tab_nx   = o_table;
    start_ok = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          start_ok = 1'b1;
          state_nx = FIRST;
          vec_nx   = 5'd0;
          wait_nx  = 4'd0;
          tab_nx   = 32'd0;
        end
      end
      DRIVE: begin
        if (wait_cnt == WAIT_LAST) state_nx = SAMPLE;
        else                       wait_nx  = wait_cnt + 4'd1;
      end
      SAMPLE: begin
        tab_nx[vec] = i_f;
        wait_nx     = 4'd0;
        if (vec == 5'd31) begin
          state_nx = DONE;
        end else begin
          vec_nx   = vec + 5'd1;
          state_nx = FIRST;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_nx  = (state_nx == DRIVE) || (state_nx == SAMPLE);
    done_nx  = (state_nx == DONE);
    drive_nx = busy_nx ? vec_nx : 5'd0;

`ifdef GATE_SWEEP_COMPARE_EN
    match_nx = o_match;
    if (start_ok) match_nx = 1'b0;
    if ((state == SAMPLE) && (vec == 5'd31)) match_nx = (tab_nx == i_expect);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      vec      <= 5'd0;
      wait_cnt <= 4'd0;
      o_table  <= 32'd0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_code   <= 2'd0;
      o_a      <= 1'b0;
      o_b      <= 1'b0;
      o_c      <= 1'b0;
`ifdef GATE_SWEEP_COMPARE_EN
      o_match  <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      vec      <= vec_nx;
      wait_cnt <= wait_nx;
      o_table  <= tab_nx;
      o_busy   <= busy_nx;
      o_done   <= done_nx;
      o_code   <= drive_nx[4:3];
      o_a      <= drive_nx[2];
      o_b      <= drive_nx[1];
      o_c      <= drive_nx[0];
`ifdef GATE_SWEEP_COMPARE_EN
      o_match  <= match_nx;
`endif
    end
  end

endmodule

// File: tb/tb_gate_truth_table_sweep.sv
// Bench for gate_truth_table_sweep: SETTLE=1 and SETTLE=0 instances fed by a behavioural gate model.
module tb_gate_truth_table_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, f_tie, sel;
  logic [31:0] expect_val;

  logic        a1, b1, c1, f1, busy1, done1;
  logic [1:0]  code1;
  logic [31:0] tab1;
  logic        a0, b0, c0, f0, busy0, done0;
  logic [1:0]  code0;
  logic [31:0] tab0;
`ifdef GATE_SWEEP_COMPARE_EN
  logic        match1, match0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] tab;
    logic [15:0] cyc;
  } exp_t;
  exp_t sb[$];

  function automatic logic gate(input logic [1:0] code, input logic a, input logic b, input logic c);
    case (code)
      2'd0:    gate = a & b & c;
      2'd1:    gate = a | b | c;
      2'd2:    gate = a ^ b ^ c;
      default: gate = ~(a & b & c);
    endcase
  endfunction

  assign f1 = f_tie ? 1'b1 : gate(code1, a1, b1, c1);
  assign f0 = f_tie ? 1'b1 : gate(code0, a0, b0, c0);

  gate_truth_table_sweep #(.SETTLE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_a(a1), .o_b(b1), .o_c(c1), .o_code(code1), .i_f(f1),
    .o_busy(busy1), .o_done(done1), .o_table(tab1)
`ifdef GATE_SWEEP_COMPARE_EN
    , .i_expect(expect_val), .o_match(match1)
`endif
  );

  gate_truth_table_sweep #(.SETTLE(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_a(a0), .o_b(b0), .o_c(c0), .o_code(code0), .i_f(f0),
    .o_busy(busy0), .o_done(done0), .o_table(tab0)
`ifdef GATE_SWEEP_COMPARE_EN
    , .i_expect(expect_val), .o_match(match0)
`endif
  );

  logic        obs_busy, obs_done;
  logic [4:0]  obs_drv;
  logic [31:0] obs_tab;
  assign obs_busy = sel ? busy0 : busy1;
  assign obs_done = sel ? done0 : done1;
  assign obs_drv  = sel ? {code0, a0, b0, c0} : {code1, a1, b1, c1};
  assign obs_tab  = sel ? tab0 : tab1;

  // Pulses start across one edge and returns at the negedge of cycle 1.
  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy0 || busy1 || done0 || done1) && n < budget) begin
      @(negedge clk); n++;
    end
    n_checks++;
    if (busy0 || busy1 || done0 || done1) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b%b done=%b%b required all 0", busy1, busy0, done1, done0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy1, done1, code1, a1, b1, c1} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctl1: got %b required 0", {busy1, done1, code1, a1, b1, c1});
    end
    n_checks++;
    if (tab1 !== 32'd0) begin n_fail++; $display("FAIL reset_tab1: got %h required 0", tab1); end
    n_checks++;
    if ({busy0, done0, code0, a0, b0, c0} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctl0: got %b required 0", {busy0, done0, code0, a0, b0, c0});
    end
    n_checks++;
    if (tab0 !== 32'd0) begin n_fail++; $display("FAIL reset_tab0: got %h required 0", tab0); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tied_one();
    exp_t e;
    logic [4:0] ev;
    sel = 1'b0; f_tie = 1'b1;
    sb.push_back({32'hFFFF_FFFF, 16'd65});
    kick();
    for (int k = 1; k <= 90; k++) begin
      ev = (k < 65) ? 5'((k - 1) / 2) : 5'd0;
      n_checks++;
      if (obs_busy !== (k < 65)) begin
        n_fail++; $display("FAIL tied_busy c%0d: got %b required %b", k, obs_busy, (k < 65));
      end
      n_checks++;
      if (obs_drv !== ev) begin
        n_fail++; $display("FAIL tied_drive c%0d: got %h required %h", k, obs_drv, ev);
      end
      n_checks++;
      if (obs_done !== (k == 65)) begin
        n_fail++; $display("FAIL tied_done c%0d: got %b required %b", k, obs_done, (k == 65));
      end
      if (obs_done && sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (obs_tab !== e.tab || 16'(k) !== e.cyc) begin
          n_fail++; $display("FAIL tied_result: table %h cycle %0d required %h cycle %0d", obs_tab, k, e.tab, e.cyc);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL tied_timeout: %0d results outstanding required 0", sb.size()); end
    sb.delete();
    n_checks++;
    if (obs_tab !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tied_hold: got %h required ffffffff", obs_tab); end
    f_tie = 1'b0;
    wait_idle(200);
  endtask

  task automatic test_gate_model();
    exp_t e;
    sel = 1'b0;
    sb.push_back({32'h7F96_FE80, 16'd65});
    kick();
    for (int k = 1; k <= 80; k++) begin
      if (obs_done) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL gate_extra_done c%0d: got done required none", k);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (obs_tab !== e.tab || 16'(k) !== e.cyc) begin
            n_fail++; $display("FAIL gate_result: table %h cycle %0d required %h cycle %0d", obs_tab, k, e.tab, e.cyc);
          end
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL gate_timeout: %0d results outstanding required 0", sb.size()); end
    sb.delete();
    n_checks++;
    if (obs_tab !== 32'h7F96_FE80 || obs_drv !== 5'd0) begin
      n_fail++; $display("FAIL gate_hold: table %h drive %h required 7f96fe80 00", obs_tab, obs_drv);
    end
    wait_idle(200);
  endtask

  task automatic test_settle0();
    exp_t e;
    sel = 1'b1;
    sb.push_back({32'h7F96_FE80, 16'd33});
    kick();
    for (int k = 1; k <= 90; k++) begin
      start = (k == 5 || k == 20);
      n_checks++;
      if (obs_busy !== (k < 33)) begin
        n_fail++; $display("FAIL s0_busy c%0d: got %b required %b", k, obs_busy, (k < 33));
      end
      n_checks++;
      if (obs_done !== (k == 33)) begin
        n_fail++; $display("FAIL s0_done c%0d: got %b required %b", k, obs_done, (k == 33));
      end
      if (obs_done && sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (obs_tab !== e.tab || 16'(k) !== e.cyc) begin
          n_fail++; $display("FAIL s0_result: table %h cycle %0d required %h cycle %0d", obs_tab, k, e.tab, e.cyc);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL s0_timeout: %0d results outstanding required 0", sb.size()); end
    sb.delete();
    wait_idle(200);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic eb;
    sel = 1'b0;
    sb.push_back({32'h7F96_FE80, 16'd65});
    sb.push_back({32'h7F96_FE80, 16'd131});
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 140; k++) begin
      eb = !(k == 65 || k == 66 || k == 131 || k == 132);
      n_checks++;
      if (obs_busy !== eb) begin
        n_fail++; $display("FAIL b2b_busy c%0d: got %b required %b", k, obs_busy, eb);
      end
      if (obs_done) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_done c%0d: got done required none", k);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (obs_tab !== e.tab || 16'(k) !== e.cyc) begin
            n_fail++; $display("FAIL b2b_result: table %h cycle %0d required %h cycle %0d", obs_tab, k, e.tab, e.cyc);
          end
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_timeout: %0d results outstanding required 0", sb.size()); end
    sb.delete();
    wait_idle(300);
  endtask

  task automatic test_mid_reset();
    exp_t e;
    sel = 1'b0;
    kick();
    repeat (19) @(negedge clk);
    n_checks++;
    if (obs_tab !== 32'h0000_0080) begin n_fail++; $display("FAIL mid_partial: got %h required 00000080", obs_tab); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({obs_busy, obs_done, obs_drv} !== 7'd0 || obs_tab !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset: busy %b done %b drive %h table %h required all 0", obs_busy, obs_done, obs_drv, obs_tab);
    end
    sb.push_back({32'h7F96_FE80, 16'd65});
    kick();
    for (int k = 1; k <= 80; k++) begin
      if (obs_done && sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (obs_tab !== e.tab || 16'(k) !== e.cyc) begin
          n_fail++; $display("FAIL mid_result: table %h cycle %0d required %h cycle %0d", obs_tab, k, e.tab, e.cyc);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL mid_timeout: %0d results outstanding required 0", sb.size()); end
    sb.delete();
    wait_idle(200);
  endtask

`ifdef GATE_SWEEP_COMPARE_EN
  task automatic test_compare();
    expect_val = 32'h7F96_FE80;
    kick();
    repeat (70) @(negedge clk);
    n_checks++;
    if (match1 !== 1'b1 || match0 !== 1'b1) begin
      n_fail++; $display("FAIL cmp_equal: match %b%b required 11", match1, match0);
    end
    expect_val = 32'h7F96_FE81;
    kick();
    n_checks++;
    if (match1 !== 1'b0 || match0 !== 1'b0) begin
      n_fail++; $display("FAIL cmp_clear: match %b%b required 00", match1, match0);
    end
    repeat (70) @(negedge clk);
    n_checks++;
    if (match1 !== 1'b0 || match0 !== 1'b0) begin
      n_fail++; $display("FAIL cmp_differ: match %b%b required 00", match1, match0);
    end
    wait_idle(200);
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; f_tie = 1'b0; sel = 1'b0; expect_val = 32'd0;
    test_reset();
    test_tied_one();
    test_gate_model();
    test_settle0();
    test_back_to_back();
    test_mid_reset();
`ifdef GATE_SWEEP_COMPARE_EN
    test_compare();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_sweep.md
GATE_TRUTH_TABLE_SWEEP -- requirements
Module: gate_truth_table_sweep

Interface
REQ-001 Parameter: SETTLE, 1, number of extra hold cycles per vector before sampling; legal range 0..15.
REQ-002 Port: i_clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: i_rst  input  1  reset; synchronous, active-high.
REQ-004 Port: i_start  input  1  sweep request; sampled only in IDLE.
REQ-005 Port: o_a  output  1  drives input a of the downstream three-input gate.
REQ-006 Port: o_b  output  1  drives input b of the gate.
REQ-007 Port: o_c  output  1  drives input c of the gate.
REQ-008 Port: o_code  output  2  drives the i_code function select of the gate.
REQ-009 Port: i_f  input  1  gate output o_f, sampled by this block.
REQ-010 Port: o_busy  output  1  high while a sweep is in progress.
REQ-011 Port: o_done  output  1  one-cycle pulse when the sweep completes.
REQ-012 Port: o_table  output  32  captured truth table; bit index = vector number.

Function
REQ-013 The block SHALL sweep 32 vectors, vec = 0..31, with o_code = vec[4:3], o_a = vec[2], o_b = vec[1], o_c = vec[0].
REQ-014 The state machine SHALL have the states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 IDLE -> DRIVE (or SAMPLE if SETTLE=0) on i_start=1; in the same edge vec:=0 and o_table:=0.
REQ-016 DRIVE SHALL last exactly SETTLE cycles, counted by a wait counter, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle; at its closing edge o_table[vec]:=i_f.
REQ-018 After SAMPLE: if vec=31 go to DONE, else vec:=vec+1 and go to DRIVE (or SAMPLE if SETTLE=0).
REQ-019 DONE SHALL last one cycle with o_done=1, then go to IDLE.
REQ-020 Drive outputs SHALL be registered, hold the vec value throughout DRIVE and SAMPLE, and be 0 in IDLE and DONE.
REQ-021 o_busy SHALL be 1 in DRIVE and SAMPLE, and 0 in IDLE and DONE.
REQ-022 With i_start accepted at edge 0, o_done SHALL be high in cycle 1+32*(SETTLE+1); for SETTLE=1 that is cycle 65.
REQ-023 i_start SHALL be ignored outside IDLE; a sweep is never restarted or extended.
REQ-024 o_table SHALL hold its value from DONE until the next accepted i_start.
REQ-025 i_start held high continuously SHALL start back-to-back sweeps, one per IDLE visit.

Reset
REQ-026 When i_rst=1 at an edge, the block SHALL go to IDLE and clear vec, the wait counter, o_table, o_a, o_b, o_c, o_code, o_busy and o_done.
REQ-027 i_rst SHALL take priority over i_start and over every state transition, including in mid-sweep.

Configuration
REQ-028 Macro GATE_SWEEP_COMPARE_EN defined: add ports i_expect (input, 32) and o_match (output, 1).
REQ-029 With the macro, o_match:=(final o_table == i_expect) at the edge that enters DONE, and o_match is held until the next start.
REQ-030 With the macro, o_match SHALL be cleared by reset and at start acceptance.
REQ-031 Macro undefined: i_expect, o_match and the compare logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 i_f tied to 1, SETTLE=1, start at cycle 0 -> o_done only in cycle 65, o_table=32'hFFFF_FFFF, o_busy cycles 1..64.
REQ-033 Gate model code0=AND, code1=OR, code2=XOR, code3=NAND -> o_table=32'h7F96_FE80.
REQ-034 SETTLE=0 with the same gate model -> o_done in cycle 33, o_table=32'h7F96_FE80; extra i_start pulses at cycles 5 and 20 change nothing.
REQ-035 i_rst at cycle 20 of a sweep -> next cycle o_busy=0, o_table=0, drive outputs 0; a new start completes with the correct table.
REQ-036 GATE_SWEEP_COMPARE_EN, gate model as in REQ-033, i_expect=32'h7F96_FE80 -> o_match=1; i_expect=32'h7F96_FE81 -> o_match=0.
